spm_product_deser: RTL and testbench

- Receive side of the bit-serial product stream produced by the signed 8x8 serial-parallel multiplier datapath (serial carry-save adder chain output).
- Collects PROD_W product bits, LSB-first, into a parallel signed word.
- Presents the word on a valid/ready handshake to the downstream consumer.
- Flags protocol errors: new frame while a result is still held, and frame restart mid-shift.

---
 rtl/spm_pkg.sv | 17 +
 rtl/spm_bit_counter.sv | 31 +++
 rtl/spm_product_deser.sv | 141 ++++++++++++++
 tb/tb_spm_product_deser.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier product path.
package spm_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int OPND_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int CNT_W(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/spm_bit_counter.sv
// Bit counter for the product deserialiser: load-to-1, increment, clear,
// with a terminal-count flag at LAST.
module spm_bit_counter #(
    parameter int W    = 4,
    parameter int LAST = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    input  logic clr,
    output logic tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(1);
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(LAST));

endmodule

// File: rtl/spm_product_deser.sv
// Deserialises the LSB-first product stream into a signed word and offers
// it on a valid/ready handshake, flagging frame protocol errors.
module spm_product_deser
    import spm_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              bit_i,
    input  logic              bit_vld_i,
    output logic [PROD_W-1:0] product_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int CW = CNT_W(PROD_W);

    state_t            state;
    state_t            state_nx;
    logic [PROD_W-1:0] shreg;
    logic              take_start;
    logic              shift_en;
    logic              cnt_load;
    logic              cnt_inc;
    logic              cnt_clr;
    logic              cnt_tc;
    logic              capture;
    logic              err_set;
    logic              valid_clr;

    assign take_start = start_i & bit_vld_i;

    spm_bit_counter #(
        .W    (CW),
        .LAST (PROD_W - 1)
    ) u_cnt (
        .clk  (clk_i),
        .rst  (rst_i),
        .load (cnt_load),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .tc   (cnt_tc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        shift_en  = 1'b0;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        capture   = 1'b0;
        err_set   = 1'b0;
        valid_clr = 1'b0;
        case (state)
            IDLE: begin
                if (take_start) begin
                    state_nx = SHIFT;
                    shift_en = 1'b1;
                    cnt_load = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_vld_i) begin
                    shift_en = 1'b1;
                    if (start_i) begin
                        err_set  = 1'b1;
                        cnt_load = 1'b1;
                    end else if (cnt_tc) begin
                        capture  = 1'b1;
                        cnt_clr  = 1'b1;
                        state_nx = HOLD;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (ready_i) begin
                    valid_clr = 1'b1;
                    state_nx  = IDLE;
                    // Handshake and a new start in one cycle chain back-to-back.
                    if (take_start) begin
                        state_nx = SHIFT;
                        shift_en = 1'b1;
                        cnt_load = 1'b1;
                    end
                end else if (take_start) begin
                    err_set = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg     <= '0;
            product_o <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            if (shift_en) begin
                // A new frame start drops any partial data already shifted in.
                if (cnt_load) begin
                    shreg <= '0;
                    shreg[PROD_W-1] <= bit_i;
                end else begin
                    shreg <= {bit_i, shreg[PROD_W-1:1]};
                end
            end
            if (capture) begin
                product_o <= {bit_i, shreg[PROD_W-1:1]};
            end
            if (capture) begin
                valid_o <= 1'b1;
            end else if (valid_clr) begin
                valid_o <= 1'b0;
            end
            if (err_set) begin
                err_o <= 1'b1;
            end
            busy_o <= (state_nx == SHIFT);
        end
    end

endmodule

// File: tb/tb_spm_product_deser.sv
// Directed-vector bench for spm_product_deser (16-bit products).
module tb_spm_product_deser;

    logic        clk;
    logic        rst;
    logic        start;
    logic        bit_in;
    logic        bit_vld;
    logic [15:0] product;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    spm_product_deser #(.PROD_W(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .bit_i     (bit_in),
        .bit_vld_i (bit_vld),
        .product_o (product),
        .valid_o   (valid),
        .ready_i   (ready),
        .busy_o    (busy),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic s, input logic b, input logic v,
                        input logic r);
        start   = s;
        bit_in  = b;
        bit_vld = v;
        ready   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] val, input logic rdy,
                              input int stall_pct, input string tag);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                for (int k = 0; k < 3; k++) begin
                    if ($urandom_range(0, 99) < stall_pct) begin
                        tick(1'b0, 1'b0, 1'b0, rdy);
                        chk({tag, "_stall_busy"}, 64'(busy), 64'd1);
                        chk({tag, "_stall_valid"}, 64'(valid), 64'd0);
                    end
                end
            end
            tick(i == 0, val[i], 1'b1, rdy);
            chk({tag, "_busy"}, 64'(busy), 64'(i != 15));
            chk({tag, "_valid"}, 64'(valid), 64'(i == 15));
        end
    endtask

    initial begin
        logic [15:0] v;
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_product", 64'(product), 64'd0);

        // Start without bit_vld is ignored
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        chk("idle_start_novld", 64'(busy), 64'd0);

        send_frame(16'hFFF1, 1'b1, 0, "basic");
        chk("basic_product", 64'(product), 64'hFFF1);
        chk("basic_err", 64'(err), 64'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_hs_valid", 64'(valid), 64'd0);
        chk("basic_hs_keep", 64'(product), 64'hFFF1);

        send_frame(16'h3F01, 1'b1, 30, "stall");
        chk("stall_product", 64'(product), 64'h3F01);
        chk("stall_err", 64'(err), 64'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("stall_hs_valid", 64'(valid), 64'd0);

        send_frame(16'hFFF1, 1'b0, 0, "bp");
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0);
            chk("bp_hold_valid", 64'(valid), 64'd1);
            chk("bp_hold_product", 64'(product), 64'hFFF1);
        end
        chk("bp_err_before", 64'(err), 64'd0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        chk("bp_drop_err", 64'(err), 64'd1);
        chk("bp_drop_valid", 64'(valid), 64'd1);
        chk("bp_drop_busy", 64'(busy), 64'd0);
        chk("bp_drop_product", 64'(product), 64'hFFF1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_hs_valid", 64'(valid), 64'd0);
        chk("bp_hs_busy", 64'(busy), 64'd0);
        chk("bp_hs_err", 64'(err), 64'd1);
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("bp_rst_err", 64'(err), 64'd0);

        send_frame(16'h4000, 1'b1, 0, "b2b1");
        chk("b2b1_product", 64'(product), 64'h4000);
        send_frame(16'hFF80, 1'b1, 0, "b2b2");
        chk("b2b2_product", 64'(product), 64'hFF80);
        chk("b2b_err", 64'(err), 64'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_hs_valid", 64'(valid), 64'd0);

        v = 16'hAAAA;
        for (int i = 0; i < 7; i++) begin
            tick(i == 0, v[i], 1'b1, 1'b1);
        end
        chk("rs_pre_err", 64'(err), 64'd0);
        v = 16'h0015;
        tick(1'b1, v[0], 1'b1, 1'b1);
        chk("rs_err", 64'(err), 64'd1);
        chk("rs_busy", 64'(busy), 64'd1);
        for (int i = 1; i < 16; i++) begin
            tick(1'b0, v[i], 1'b1, 1'b1);
            chk("rs_valid", 64'(valid), 64'(i == 15));
        end
        chk("rs_product", 64'(product), 64'h0015);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        v = 16'h1234;
        for (int i = 0; i < 9; i++) begin
            tick(i == 0, v[i], 1'b1, 1'b1);
        end
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        chk("mrst_valid", 64'(valid), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_err", 64'(err), 64'd0);
        chk("mrst_product", 64'(product), 64'd0);
        send_frame(16'h8001, 1'b1, 0, "post");
        chk("post_product", 64'(product), 64'h8001);
        chk("post_err", 64'(err), 64'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
